spectral_shaper: RTL and testbench

Frequency-domain complex-multiply stage that sits between the forward FFT and the IFFT in the wave-synthesis path. Each incoming spectrum bin is multiplied by a per-bin complex coefficient held in an internal, runtime-writable RAM. The product is rounded and saturated, then streamed out with AXI-Stream handshakes. This generalises the fixed single-multiplier hookup by adding several capabilities:

- parametrised widths and frame length
- per-bin coefficient storage indexed by an internal bin counter
- bypass, conjugate and mute modes
- backpressure handling
- frame-boundary checking

---
 rtl/spectral_shaper.sv | 226 ++++++++++++++++++++++
 tb/tb_spectral_shaper.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_shaper.sv
// Per-bin complex multiply of a streamed spectrum by a runtime-writable coefficient RAM.
// Three-stage pipeline with a single global stall; rounds half-up and saturates each component.
module spectral_shaper #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned LOG2N = 10,
  parameter int unsigned FRAC  = 14
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [1:0]          mode,
  input  logic [2*DW-1:0]     s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                coef_we,
  input  logic [LOG2N-1:0]    coef_waddr,
  input  logic [2*CW-1:0]     coef_wdata,
  output logic [2*DW-1:0]     m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                err_tlast_early,
  output logic                err_tlast_missing,
  output logic                sat_frame
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned PW = DW + CW;
  // Sum needs PW+1 bits; one more bit keeps the rounding add from wrapping.
  localparam int unsigned SW = PW + 2;

  localparam logic [LOG2N-1:0]   LastBin = {LOG2N{1'b1}};
  localparam logic signed [SW-1:0] RndC  = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MaxV  = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MinV  = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ModeBypass = 2'b00,
    ModeMul    = 2'b01,
    ModeConj   = 2'b10,
    ModeMute   = 2'b11
  } mode_e;

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
    return $signed({{2{p[PW-1]}}, p});
  endfunction

  logic                 advance, accept, beat_last;
  logic [LOG2N-1:0]     bin_q;
  mode_e                frame_mode_q, beat_mode;

  // Stage 1
  logic                 v1_q, l1_q;
  logic [2*DW-1:0]      a1_q;
  mode_e                m1_q;
  logic [2*CW-1:0]      coef1_q;
  logic [2*CW-1:0]      ram [N];

  // Stage 2
  logic                 v2_q, l2_q;
  logic [2*DW-1:0]      a2_q;
  mode_e                m2_q;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  // Stage 3
  logic signed [SW-1:0] sum_re, sum_im, sh_re, sh_im;
  logic [DW-1:0]        res_re, res_im;
  logic                 ovf_re, ovf_im;
  logic [2*DW-1:0]      nxt_data;
  logic                 nxt_sat;
  logic                 sat3_q, sticky_q;

  assign advance   = !m_tvalid || m_tready;
  assign s_tready  = advance;
  assign accept    = s_tvalid && advance;
  assign beat_last = (bin_q == LastBin) || s_tlast;
  // Bin 0 takes the live mode; later bins use the value latched at bin 0.
  assign beat_mode = (bin_q == '0) ? mode_e'(mode) : frame_mode_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q             <= '0;
      frame_mode_q      <= ModeBypass;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else begin
      err_tlast_early   <= accept && s_tlast && (bin_q != LastBin);
      err_tlast_missing <= accept && !s_tlast && (bin_q == LastBin);
      if (accept) begin
        bin_q <= beat_last ? '0 : bin_q + 1'b1;
        if (bin_q == '0) frame_mode_q <= mode_e'(mode);
      end
    end
  end

  // Read-first RAM: a same-cycle write to the read address yields the old word.
  always_ff @(posedge sys_clk) begin
    if (coef_we) ram[coef_waddr] <= coef_wdata;
    if (advance) coef1_q <= ram[bin_q];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      a1_q <= '0;
      m1_q <= ModeBypass;
    end else if (advance) begin
      v1_q <= accept;
      l1_q <= beat_last;
      a1_q <= s_tdata;
      m1_q <= beat_mode;
    end
  end

  always_comb begin
    p_rr = $signed({{CW{a1_q[2*DW-1]}}, a1_q[2*DW-1:DW]})
         * $signed({{DW{coef1_q[2*CW-1]}}, coef1_q[2*CW-1:CW]});
    p_ii = $signed({{CW{a1_q[DW-1]}}, a1_q[DW-1:0]})
         * $signed({{DW{coef1_q[CW-1]}}, coef1_q[CW-1:0]});
    p_ri = $signed({{CW{a1_q[2*DW-1]}}, a1_q[2*DW-1:DW]})
         * $signed({{DW{coef1_q[CW-1]}}, coef1_q[CW-1:0]});
    p_ir = $signed({{CW{a1_q[DW-1]}}, a1_q[DW-1:0]})
         * $signed({{DW{coef1_q[2*CW-1]}}, coef1_q[2*CW-1:CW]});
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v2_q   <= 1'b0;
      l2_q   <= 1'b0;
      a2_q   <= '0;
      m2_q   <= ModeBypass;
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
    end else if (advance) begin
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      a2_q   <= a1_q;
      m2_q   <= m1_q;
      p_rr_q <= p_rr;
      p_ii_q <= p_ii;
      p_ri_q <= p_ri;
      p_ir_q <= p_ir;
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    if (m2_q == ModeConj) begin
      sum_re = sx(p_rr_q) + sx(p_ii_q);
      sum_im = sx(p_ir_q) - sx(p_ri_q);
    end else begin
      sum_re = sx(p_rr_q) - sx(p_ii_q);
      sum_im = sx(p_ri_q) + sx(p_ir_q);
    end
    sh_re = (sum_re + RndC) >>> FRAC;
    sh_im = (sum_im + RndC) >>> FRAC;

    ovf_re = 1'b0;
    res_re = sh_re[DW-1:0];
    if (sh_re > MaxV) begin
      ovf_re = 1'b1;
      res_re = {1'b0, {(DW-1){1'b1}}};
    end else if (sh_re < MinV) begin
      ovf_re = 1'b1;
      res_re = {1'b1, {(DW-1){1'b0}}};
    end
    ovf_im = 1'b0;
    res_im = sh_im[DW-1:0];
    if (sh_im > MaxV) begin
      ovf_im = 1'b1;
      res_im = {1'b0, {(DW-1){1'b1}}};
    end else if (sh_im < MinV) begin
      ovf_im = 1'b1;
      res_im = {1'b1, {(DW-1){1'b0}}};
    end

    nxt_data = {res_re, res_im};
    nxt_sat  = ovf_re || ovf_im;
    case (m2_q)
      ModeBypass: begin
        nxt_data = a2_q;
        nxt_sat  = 1'b0;
      end
      ModeMute: begin
        nxt_data = '0;
        nxt_sat  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      sat3_q   <= 1'b0;
    end else if (advance) begin
      m_tvalid <= v2_q;
      m_tdata  <= nxt_data;
      m_tlast  <= l2_q;
      sat3_q   <= nxt_sat && v2_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sticky_q  <= 1'b0;
      sat_frame <= 1'b0;
    end else if (m_tvalid && m_tready) begin
      if (m_tlast) begin
        sat_frame <= sticky_q || sat3_q;
        sticky_q  <= 1'b0;
      end else begin
        sticky_q  <= sticky_q || sat3_q;
      end
    end
  end

endmodule

// File: tb/tb_spectral_shaper.sv
// Directed bench for spectral_shaper: single-beat vector table plus frame, stall and reset sequences.
module tb_spectral_shaper;

  localparam int N = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        coef_we = 1'b0;
  logic [9:0]  coef_waddr = '0;
  logic [31:0] coef_wdata = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        err_tlast_early;
  logic        err_tlast_missing;
  logic        sat_frame;

  logic bp_en = 1'b0;
  logic bp_t  = 1'b0;
  assign m_tready = !bp_en || bp_t;

  spectral_shaper dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .mode              (mode),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .s_tlast           (s_tlast),
    .coef_we           (coef_we),
    .coef_waddr        (coef_waddr),
    .coef_wdata        (coef_wdata),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tready          (m_tready),
    .m_tlast           (m_tlast),
    .err_tlast_early   (err_tlast_early),
    .err_tlast_missing (err_tlast_missing),
    .sat_frame         (sat_frame)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    bp_t = ~bp_t;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t oq[$];

  int          early_cnt = 0;
  int          miss_cnt = 0;
  int          rdy_bad = 0;
  int          stab_bad = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  // Values seen at the falling edge are those the DUT samples on the next rising edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (m_tvalid && m_tready) oq.push_back('{d: m_tdata, l: m_tlast});
      if (err_tlast_early) early_cnt++;
      if (err_tlast_missing) miss_cnt++;
      if (s_tready !== (!m_tvalid || m_tready)) rdy_bad++;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l)) stab_bad++;
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input int re, input int im);
    logic [15:0] a, b;
    a = re[15:0];
    b = im[15:0];
    return {a, b};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int re, input int im);
    coef_we    = 1'b1;
    coef_waddr = addr[9:0];
    coef_wdata = pk(re, im);
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] md);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    mode     = md;
    while (!acc) begin
      @(negedge sys_clk);
      acc = s_tready;
      @(posedge sys_clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no s_tready in %0d cycles required acceptance", n);
        acc = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    bp_en = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    int md, cre, cim, are, aim, ere, eim;
    bit sat;
  } vec_t;

  vec_t vt[13] = '{
    '{1, 16384,      0,   1000,   -500,   1000,   -500, 0},
    '{1,     0,  16384,   1000,    200,   -200,   1000, 0},
    '{2,     0,  16384,   1000,    200,    200,  -1000, 0},
    '{3,     0,  16384,   1000,    200,      0,      0, 0},
    '{0,     0,  16384,   1000,    200,   1000,    200, 0},
    '{1,  8192,      0,      3,      0,      2,      0, 0},
    '{1, 16384,  16384,  32767,  32767,      0,  32767, 1},
    '{1, 16384,      0, -32768, -32768, -32768, -32768, 0},
    '{2, -16384,     0, -32768,      5,  32767,     -5, 1},
    '{1,  8192,      0,     -3,      0,     -1,      0, 0},
    '{0,  8192,      0, -32768,  32767, -32768,  32767, 0},
    '{1, -16384, -16384, -32768,     0,  32767,  32767, 1},
    '{3, 16384,      0,   1234,    -77,      0,      0, 0}
  };

  initial begin
    int   base, bad, badl, e0, m0, r0, s0;
    logic prev_sat;
    logic [31:0] exp_d;

    // Reset state
    repeat (3) tick();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_err_early", err_tlast_early, 0);
    chk("rst_err_missing", err_tlast_missing, 0);
    chk("rst_sat_frame", sat_frame, 0);
    chk("rst_s_tready", s_tready, 1);
    sys_rst_n = 1'b1;
    tick();

    // Single-beat frames at bin 0: exact latency, arithmetic, sat_frame hold/update
    prev_sat = 1'b0;
    for (int i = 0; i < 13; i++) begin
      write_coef(0, vt[i].cre, vt[i].cim);
      mode     = vt[i].md[1:0];
      s_tdata  = pk(vt[i].are, vt[i].aim);
      s_tvalid = 1'b1;
      s_tlast  = 1'b1;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      chk($sformatf("v%0d_err_early", i), err_tlast_early, 1);
      tick();
      chk($sformatf("v%0d_early_valid", i), m_tvalid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), m_tvalid, 1);
      chk($sformatf("v%0d_data", i), m_tdata, pk(vt[i].ere, vt[i].eim));
      chk($sformatf("v%0d_last", i), m_tlast, 1);
      chk($sformatf("v%0d_sat_hold", i), sat_frame, prev_sat);
      tick();
      chk($sformatf("v%0d_sat_frame", i), sat_frame, vt[i].sat);
      prev_sat = vt[i].sat;
    end

    // Full unity-gain frame
    for (int a = 0; a < N; a++) write_coef(a, 16384, 0);
    base = oq.size();
    e0   = early_cnt;
    m0   = miss_cnt;
    for (int i = 0; i < N; i++) send_beat(pk(1000, -500), (i == N - 1), 2'b01);
    drain();
    chk("unity_count", oq.size() - base, N);
    bad  = 0;
    badl = 0;
    for (int i = 0; i < N && base + i < oq.size(); i++) begin
      if (oq[base + i].d !== pk(1000, -500)) bad++;
      if (oq[base + i].l !== (i == N - 1)) badl++;
    end
    chk("unity_data_bad", bad, 0);
    chk("unity_last_bad", badl, 0);
    chk("unity_err_early", early_cnt - e0, 0);
    chk("unity_err_missing", miss_cnt - m0, 0);
    chk("unity_sat_frame", sat_frame, 0);

    // Backpressure with alternating m_tready
    base  = oq.size();
    r0    = rdy_bad;
    s0    = stab_bad;
    bp_en = 1'b1;
    for (int i = 0; i < N; i++) send_beat(pk(i, -i), (i == N - 1), 2'b01);
    drain();
    chk("bp_count", oq.size() - base, N);
    bad = 0;
    for (int i = 0; i < N && base + i < oq.size(); i++) begin
      if (oq[base + i].d !== pk(i, -i) || oq[base + i].l !== (i == N - 1)) bad++;
    end
    chk("bp_order_bad", bad, 0);
    chk("bp_ready_rule_bad", rdy_bad - r0, 0);
    chk("bp_stall_stable_bad", stab_bad - s0, 0);

    // Early tlast at bin 5, then a frame of N beats with no tlast
    write_coef(0, 8192, 0);
    base = oq.size();
    e0   = early_cnt;
    m0   = miss_cnt;
    for (int i = 0; i < 6; i++) send_beat(pk(200 * (i + 1), -400), (i == 5), 2'b01);
    drain();
    chk("early_pulse", early_cnt - e0, 1);
    chk("early_count", oq.size() - base, 6);
    chk("early_bin5_last", oq[base + 5].l, 1);
    chk("early_bin0_coef", oq[base].d, pk(100, -200));
    chk("early_bin4_last", oq[base + 4].l, 0);
    base = oq.size();
    for (int i = 0; i < N; i++) send_beat(pk(200, -400), 1'b0, 2'b01);
    drain();
    chk("miss_pulse", miss_cnt - m0, 1);
    chk("miss_no_early", early_cnt - e0, 1);
    chk("miss_count", oq.size() - base, N);
    bad  = 0;
    badl = 0;
    for (int i = 0; i < N && base + i < oq.size(); i++) begin
      exp_d = (i == 0) ? pk(100, -200) : pk(200, -400);
      if (oq[base + i].d !== exp_d) bad++;
      if (oq[base + i].l !== (i == N - 1)) badl++;
    end
    chk("miss_data_bad", bad, 0);
    chk("miss_last_bad", badl, 0);

    // Reset at bin 300 discards in-flight beats and restarts at bin 0
    write_coef(0, 0, 16384);
    for (int i = 0; i < 300; i++) send_beat(pk(7, 7), 1'b0, 2'b01);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_tvalid, 0);
    chk("midrst_ready", s_tready, 1);
    tick();
    sys_rst_n = 1'b1;
    tick();
    base = oq.size();
    send_beat(pk(1000, 200), 1'b1, 2'b01);
    drain();
    chk("midrst_count", oq.size() - base, 1);
    chk("midrst_bin0_coef", oq[base].d, pk(-200, 1000));

    // Coefficient write to the address being read: old word wins for that beat
    base       = oq.size();
    coef_we    = 1'b1;
    coef_waddr = '0;
    coef_wdata = pk(16384, 0);
    send_beat(pk(1000, 200), 1'b1, 2'b01);
    coef_we    = 1'b0;
    send_beat(pk(1000, 200), 1'b1, 2'b01);
    drain();
    chk("rw_count", oq.size() - base, 2);
    chk("rw_old_coef", oq[base].d, pk(-200, 1000));
    chk("rw_new_coef", oq[base + 1].d, pk(1000, 200));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
